// File: rtl/trigger_delay_meter_if.sv
// Control/result bundle for trigger_delay_meter: arm/start/stop/timeout in,
// status and coarse/fine result out.
interface trigger_delay_meter_if #(
    parameter int CNT_W = 16
);
    logic             arm;
    logic             start_in;
    logic             stop_in;
    logic [CNT_W-1:0] timeout_in;
    logic             busy;
    logic             done;
    logic             valid;
    logic             timed_out;
    logic [CNT_W-1:0] coarse_out;
    logic [CNT_W-1:0] fine_out;

    modport master (
        output arm, start_in, stop_in, timeout_in,
        input  busy, done, valid, timed_out, coarse_out, fine_out
    );

    modport slave (
        input  arm, start_in, stop_in, timeout_in,
        output busy, done, valid, timed_out, coarse_out, fine_out
    );
endinterface

// File: rtl/trigger_delay_meter.sv
// Measures cycles from a start_in rising edge to the next stop_in rising edge,
// reported as whole BLOCK_CYC blocks (coarse) plus leftover cycles (fine).
module trigger_delay_meter #(
    parameter int CNT_W     = 16,
    parameter int BLOCK_CYC = 578
) (
    input logic                   clk,
    input logic                   rst_in,
    trigger_delay_meter_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] FINE_LAST = CNT_W'(BLOCK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [1:0]       state_q, state_d;
    logic             start_prev_q, start_prev_d;
    logic             stop_prev_q, stop_prev_d;
    logic [CNT_W-1:0] coarse_q, coarse_d;
    logic [CNT_W-1:0] fine_q, fine_d;
    logic [CNT_W-1:0] coarse_out_q, coarse_out_d;
    logic [CNT_W-1:0] fine_out_q, fine_out_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic             timed_out_q, timed_out_d;

    logic             start_edge, stop_edge;
    logic             fine_wrap, tmo_hit;
    logic [CNT_W-1:0] fine_inc, coarse_inc;

    always_comb begin
        start_edge = bus.start_in & ~start_prev_q;
        stop_edge  = bus.stop_in & ~stop_prev_q;
        // The count latched at a stop edge includes the stop cycle itself,
        // so decisions are made on the incremented value.
        fine_wrap  = (fine_q == FINE_LAST);
        fine_inc   = fine_wrap ? '0 : fine_q + CNT_W'(1);
        coarse_inc = fine_wrap ? coarse_q + CNT_W'(1) : coarse_q;
        // Saturating at CNT_MAX also guards against a timeout_in lowered
        // below the running count mid-measurement.
        tmo_hit    = ((bus.timeout_in != '0) && (coarse_inc == bus.timeout_in)) ||
                     (coarse_inc == CNT_MAX);

        state_d      = state_q;
        start_prev_d = bus.start_in;
        stop_prev_d  = bus.stop_in;
        coarse_d     = coarse_q;
        fine_d       = fine_q;
        coarse_out_d = coarse_out_q;
        fine_out_d   = fine_out_q;
        done_d       = 1'b0;
        valid_d      = valid_q;
        timed_out_d  = timed_out_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.arm) begin
                    state_d     = S_ARMED;
                    valid_d     = 1'b0;
                    timed_out_d = 1'b0;
                    coarse_d    = '0;
                    fine_d      = '0;
                end
            end
            S_ARMED: begin
                if (bus.arm || start_edge) begin
                    state_d  = bus.arm ? S_ARMED : S_COUNT;
                    coarse_d = '0;
                    fine_d   = '0;
                end
            end
            S_COUNT: begin
                if (bus.arm) begin
                    state_d  = S_ARMED;
                    coarse_d = '0;
                    fine_d   = '0;
                end else begin
                    coarse_d = coarse_inc;
                    fine_d   = fine_inc;
                    if (stop_edge || tmo_hit) begin
                        state_d      = S_DONE;
                        coarse_out_d = coarse_inc;
                        fine_out_d   = fine_inc;
                        done_d       = 1'b1;
                        valid_d      = 1'b1;
                        timed_out_d  = ~stop_edge;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b1;
            stop_prev_q  <= 1'b1;
            coarse_q     <= '0;
            fine_q       <= '0;
            coarse_out_q <= '0;
            fine_out_q   <= '0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            timed_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            stop_prev_q  <= stop_prev_d;
            coarse_q     <= coarse_d;
            fine_q       <= fine_d;
            coarse_out_q <= coarse_out_d;
            fine_out_q   <= fine_out_d;
            done_q       <= done_d;
            valid_q      <= valid_d;
            timed_out_q  <= timed_out_d;
        end
    end

    assign bus.busy       = (state_q == S_ARMED) || (state_q == S_COUNT);
    assign bus.done       = done_q;
    assign bus.valid      = valid_q;
    assign bus.timed_out  = timed_out_q;
    assign bus.coarse_out = coarse_out_q;
    assign bus.fine_out   = fine_out_q;
endmodule
